// File: rtl/red_and_stream_pkg.sv
// Shared types for the red_and_stream packet AND-reducer.
// Optional ZeroZ output is enabled by RED_AND_STREAM_ZERO_DETECT_EN.
package red_and_stream_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    RESULT = 2'd2
  } state_e;

endpackage

// File: rtl/red_and_stream_red_and.sv
// Per-word AND reduction.
module red_and_stream_red_and #(
  parameter int width = 8
) (
  input  logic [width-1:0] a,
  output logic             y
);

  assign y = &a;

endmodule

// File: rtl/red_and_stream.sv
// Streaming packet AND-reducer with saturating beat count.
// Define RED_AND_STREAM_ZERO_DETECT_EN to add the ZeroZ (NOR) output.
module red_and_stream
  import red_and_stream_pkg::*;
#(
  parameter int width    = 8,
  parameter int cntWidth = 8
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [width-1:0]    InA,
  input  logic                InValid,
  input  logic                InLast,
  output logic                InReady,
  output logic                Z,
  output logic [cntWidth-1:0] Count,
  output logic                OutValid,
  input  logic                OutReady
`ifdef RED_AND_STREAM_ZERO_DETECT_EN
  ,
  output logic                ZeroZ
`endif
);

  state_e state_q, state_d;

  logic                acc_q, acc_d;
  logic [cntWidth-1:0] cnt_q, cnt_d;
  logic                z_q, z_d;
  logic [cntWidth-1:0] count_q, count_d;

  logic                word_and;
  logic                ready;
  logic                accept;
  logic                done;
  logic [cntWidth-1:0] cnt_inc;

  red_and_stream_red_and #(
    .width(width)
  ) u_red_and (
    .a(InA),
    .y(word_and)
  );

  assign ready  = (state_q != RESULT);
  assign accept = InValid && ready;
  assign done   = (state_q == RESULT) && OutReady;
  // Saturate instead of wrapping on very long packets.
  assign cnt_inc = (cnt_q == {cntWidth{1'b1}})
                 ? cnt_q
                 : cnt_q + cntWidth'(1);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, ACCUM: begin
        if (accept) begin
          state_d = InLast ? RESULT : ACCUM;
        end
      end
      RESULT: begin
        if (OutReady) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    InReady  = ready && !RST;
    OutValid = (state_q == RESULT);
  end

  always_comb begin
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    z_d     = z_q;
    count_d = count_q;
    unique case (1'b1)
      accept: begin
        acc_d = acc_q & word_and;
        cnt_d = cnt_inc;
        if (InLast) begin
          z_d     = acc_q & word_and;
          count_d = cnt_inc;
        end
      end
      done: begin
        acc_d = 1'b1;
        cnt_d = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      acc_q   <= 1'b1;
      cnt_q   <= '0;
      z_q     <= 1'b0;
      count_q <= '0;
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      z_q     <= z_d;
      count_q <= count_d;
    end
  end

  assign Z     = z_q;
  assign Count = count_q;

`ifdef RED_AND_STREAM_ZERO_DETECT_EN
  logic zacc_q, zacc_d;
  logic zz_q, zz_d;
  logic word_zero;

  assign word_zero = &(~InA);

  always_comb begin
    zacc_d = zacc_q;
    zz_d   = zz_q;
    if (accept) begin
      zacc_d = zacc_q & word_zero;
      if (InLast) begin
        zz_d = zacc_q & word_zero;
      end
    end else if (done) begin
      zacc_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      zacc_q <= 1'b1;
      zz_q   <= 1'b0;
    end else begin
      zacc_q <= zacc_d;
      zz_q   <= zz_d;
    end
  end

  assign ZeroZ = zz_q;
`endif

endmodule

// File: tb/tb_red_and_stream.sv
// Randomized + directed bench for red_and_stream (cntWidth 8 and 2).
// Define RED_AND_STREAM_ZERO_DETECT_EN to also check ZeroZ.
module tb_red_and_stream;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] InA;
  logic       InValid, InLast, OutReady;

  logic       rdy8, z8, ov8;
  logic [7:0] cnt8;
  logic       rdy2, z2, ov2;
  logic [1:0] cnt2;
`ifdef RED_AND_STREAM_ZERO_DETECT_EN
  logic       zz8, zz2;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: packet-level bookkeeping.
  bit pend;
  bit acc, zac;
  int n;
  bit ez, ezz;
  int en;

  always #5 CLK = ~CLK;

  red_and_stream #(.width(8), .cntWidth(8)) dut8 (
    .CLK(CLK), .RST(RST), .InA(InA),
    .InValid(InValid), .InLast(InLast),
    .InReady(rdy8), .Z(z8), .Count(cnt8),
    .OutValid(ov8), .OutReady(OutReady)
`ifdef RED_AND_STREAM_ZERO_DETECT_EN
    , .ZeroZ(zz8)
`endif
  );

  red_and_stream #(.width(8), .cntWidth(2)) dut2 (
    .CLK(CLK), .RST(RST), .InA(InA),
    .InValid(InValid), .InLast(InLast),
    .InReady(rdy2), .Z(z2), .Count(cnt2),
    .OutValid(ov2), .OutReady(OutReady)
`ifdef RED_AND_STREAM_ZERO_DETECT_EN
    , .ZeroZ(zz2)
`endif
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d @%0t", nm, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_clear();
    pend = 0;
    acc  = 1;
    zac  = 1;
    n    = 0;
  endtask

  task automatic compare();
    chk("rdy8", rdy8, !pend);
    chk("rdy2", rdy2, !pend);
    chk("ov8", ov8, pend);
    chk("ov2", ov2, pend);
    if (pend) begin
      chk("z8", z8, ez);
      chk("z2", z2, ez);
      chk("cnt8", cnt8, sat(en, 255));
      chk("cnt2", cnt2, sat(en, 3));
`ifdef RED_AND_STREAM_ZERO_DETECT_EN
      chk("zz8", zz8, ezz);
      chk("zz2", zz2, ezz);
`endif
    end
  endtask

  task automatic step(input logic v, input logic [7:0] a,
                      input logic l, input logic r);
    InValid  = v;
    InA      = a;
    InLast   = l;
    OutReady = r;
    @(posedge CLK);
    if (pend) begin
      if (r) pend = 0;
    end else if (v) begin
      n++;
      acc = acc && (a == 8'hFF);
      zac = zac && (a == 8'h00);
      if (l) begin
        pend = 1;
        ez   = acc;
        ezz  = zac;
        en   = n;
        acc  = 1;
        zac  = 1;
        n    = 0;
      end
    end
    @(negedge CLK);
    compare();
  endtask

  task automatic do_reset();
    RST = 1'b1;
    #1;
    chk("rst_ov", ov8, 0);
    chk("rst_rdy", rdy8, 0);
    chk("rst_z", z8, 0);
    chk("rst_cnt", cnt8, 0);
    chk("rst_rdy2", rdy2, 0);
`ifdef RED_AND_STREAM_ZERO_DETECT_EN
    chk("rst_zz", zz8, 0);
`endif
    model_clear();
    @(negedge CLK);
    RST = 1'b0;
    #1;
    chk("post_rst_rdy", rdy8, 1);
  endtask

  initial begin
    RST = 1'b1;
    InA = '0;
    InValid = 0;
    InLast = 0;
    OutReady = 0;
    model_clear();
    @(negedge CLK);
    do_reset();

    // FF,FF,FF(last)
    step(1, 8'hFF, 0, 0);
    step(1, 8'hFF, 0, 0);
    chk("lat_ov_before", ov8, 0);
    step(1, 8'hFF, 1, 0);
    chk("p1_ov", ov8, 1);
    chk("p1_z", z8, 1);
    chk("p1_cnt", cnt8, 3);
    step(0, 8'h00, 0, 1);
    chk("p1_idle_rdy", rdy8, 1);

    // FF,7F,FF(last)
    step(1, 8'hFF, 0, 0);
    step(1, 8'h7F, 0, 0);
    step(1, 8'hFF, 1, 1);
    chk("p2_z", z8, 0);
    chk("p2_cnt", cnt8, 3);
    step(0, 8'h00, 0, 1);

    // single beat, held for 5 cycles with beats offered
    step(1, 8'hFF, 1, 0);
    for (int i = 0; i < 5; i++) begin
      step(1, 8'h00, 1, 0);
      chk("hold_rdy", rdy8, 0);
      chk("hold_z", z8, 1);
      chk("hold_cnt", cnt8, 1);
      chk("hold_ov", ov8, 1);
    end
    step(0, 8'h00, 0, 1);

    // five beats on cntWidth=2 saturate at 3
    for (int i = 0; i < 4; i++) step(1, 8'hFF, 0, 0);
    step(1, 8'hFF, 1, 0);
    chk("sat2_cnt", cnt2, 3);
    chk("sat2_z", z2, 1);
    chk("sat8_cnt", cnt8, 5);
    step(0, 8'h00, 0, 1);

    // long packet saturates cntWidth=8
    for (int i = 0; i < 299; i++) step(1, 8'hFF, 0, 0);
    step(1, 8'hFF, 1, 0);
    chk("sat8_long", cnt8, 255);
    step(0, 8'h00, 0, 1);

    // reset mid-packet
    step(1, 8'hFF, 0, 0);
    step(1, 8'hFF, 0, 0);
    do_reset();
    step(1, 8'hFF, 1, 0);
    chk("rst_pkt_cnt", cnt8, 1);
    chk("rst_pkt_z", z8, 1);
    step(0, 8'h00, 0, 1);

`ifdef RED_AND_STREAM_ZERO_DETECT_EN
    step(1, 8'h00, 0, 0);
    step(1, 8'h00, 1, 0);
    chk("zd1_zz", zz8, 1);
    chk("zd1_z", z8, 0);
    step(0, 8'h00, 0, 1);
    step(1, 8'h00, 0, 0);
    step(1, 8'h01, 1, 0);
    chk("zd2_zz", zz8, 0);
    step(0, 8'h00, 0, 1);
`endif

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] a;
      int sel;
      sel = $urandom_range(0, 9);
      if (sel < 6) a = 8'hFF;
      else if (sel < 8) a = 8'h00;
      else a = 8'($urandom);
      step(1'($urandom_range(0, 3) != 0), a,
           1'($urandom_range(0, 4) == 0),
           1'($urandom_range(0, 2) == 0));
      if (i == 1500) do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
